forward_ctrl_unit: RTL and testbench

- Producer side of the EX-stage operand forwarding path in the 5-stage pipelined CPU.
- Tracks destination-register tags of in-flight instructions through internal ID/EX, EX/MEM and MEM/WB tag registers.
- Generates the 2-bit forward selects consumed by the ALU-source operand muxes, plus the load-use stall request to PC/IF-ID.
- Sits beside the datapath pipeline registers and advances in lock-step with them.

---
 rtl/forward_ctrl_unit.sv | 81 ++++++++
 tb/tb_forward_ctrl_unit.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/forward_ctrl_unit.sv
// rtl/forward_ctrl_unit.sv - EX-stage operand forwarding selects and load-use stall
// Destination tags ride alongside the datapath pipeline registers so forward/stall decisions need no datapath state.
module forward_ctrl_unit #(
    parameter int         REG_AW    = 5,
    parameter logic [1:0] FWD_EXMEM = 2'b10,
    parameter logic [1:0] FWD_MEMWB = 2'b01
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              id_regwrite_i,
    input  logic              id_memread_i,
    input  logic              flush_i,
    output logic [1:0]        forwardA_o,
    output logic [1:0]        forwardB_o,
    output logic              stall_o,
    output logic [REG_AW-1:0] exmem_rd_o,
    output logic [REG_AW-1:0] memwb_rd_o
);

    logic [REG_AW-1:0] idex_rs1_q, idex_rs2_q, idex_rd_q;
    logic              idex_regwrite_q, idex_memread_q;
    logic [REG_AW-1:0] exmem_rd_q;
    logic              exmem_regwrite_q;
    logic [REG_AW-1:0] memwb_rd_q;
    logic              memwb_regwrite_q;

    logic exmem_valid, memwb_valid;

    // x0 is hardwired to zero, so a write to it must never be forwarded.
    assign exmem_valid = exmem_regwrite_q && (exmem_rd_q != '0);
    assign memwb_valid = memwb_regwrite_q && (memwb_rd_q != '0);

    // Youngest producer (EX/MEM) wins when both stages match.
    assign forwardA_o = (exmem_valid && exmem_rd_q == idex_rs1_q) ? FWD_EXMEM :
                        (memwb_valid && memwb_rd_q == idex_rs1_q) ? FWD_MEMWB : 2'b00;
    assign forwardB_o = (exmem_valid && exmem_rd_q == idex_rs2_q) ? FWD_EXMEM :
                        (memwb_valid && memwb_rd_q == idex_rs2_q) ? FWD_MEMWB : 2'b00;

    assign stall_o = idex_memread_q && (idex_rd_q != '0) &&
                     ((idex_rd_q == id_rs1_i) || (idex_rd_q == id_rs2_i));

    assign exmem_rd_o = exmem_rd_q;
    assign memwb_rd_o = memwb_rd_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            idex_rs1_q       <= '0;
            idex_rs2_q       <= '0;
            idex_rd_q        <= '0;
            idex_regwrite_q  <= 1'b0;
            idex_memread_q   <= 1'b0;
            exmem_rd_q       <= '0;
            exmem_regwrite_q <= 1'b0;
            memwb_rd_q       <= '0;
            memwb_regwrite_q <= 1'b0;
        end else begin
            // Stall and flush share one bubble; the later stages keep draining.
            if (stall_o || flush_i) begin
                idex_rs1_q      <= '0;
                idex_rs2_q      <= '0;
                idex_rd_q       <= '0;
                idex_regwrite_q <= 1'b0;
                idex_memread_q  <= 1'b0;
            end else begin
                idex_rs1_q      <= id_rs1_i;
                idex_rs2_q      <= id_rs2_i;
                idex_rd_q       <= id_rd_i;
                idex_regwrite_q <= id_regwrite_i;
                idex_memread_q  <= id_memread_i;
            end
            exmem_rd_q       <= idex_rd_q;
            exmem_regwrite_q <= idex_regwrite_q;
            memwb_rd_q       <= exmem_rd_q;
            memwb_regwrite_q <= exmem_regwrite_q;
        end
    end

endmodule

// File: tb/tb_forward_ctrl_unit.sv
// tb/tb_forward_ctrl_unit.sv - directed bench for forward_ctrl_unit
module tb_forward_ctrl_unit;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic [4:0] id_rs1_i = '0, id_rs2_i = '0, id_rd_i = '0;
    logic       id_regwrite_i = 1'b0, id_memread_i = 1'b0, flush_i = 1'b0;
    logic [1:0] forwardA_o, forwardB_o;
    logic       stall_o;
    logic [4:0] exmem_rd_o, memwb_rd_o;

    int total = 0;
    int passed = 0;

    forward_ctrl_unit dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i),
        .id_regwrite_i(id_regwrite_i), .id_memread_i(id_memread_i), .flush_i(flush_i),
        .forwardA_o(forwardA_o), .forwardB_o(forwardB_o), .stall_o(stall_o),
        .exmem_rd_o(exmem_rd_o), .memwb_rd_o(memwb_rd_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic set_id(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                          input logic rw, input logic mr);
        id_rs1_i = rs1; id_rs2_i = rs2; id_rd_i = rd;
        id_regwrite_i = rw; id_memread_i = mr;
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic rw, input logic mr);
        set_id(rs1, rs2, rd, rw, mr);
        step();
    endtask

    task automatic drain();
        for (int i = 0; i < 3; i++) issue(5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    endtask

    initial begin
        // Reset held with arbitrary ID traffic
        for (int i = 0; i < 3; i++) begin
            set_id(5'($urandom), 5'($urandom), 5'($urandom), 1'b1, 1'b1);
            step();
        end
        chk("rst_fwdA", 5'(forwardA_o), 5'd0);
        chk("rst_fwdB", 5'(forwardB_o), 5'd0);
        chk("rst_stall", 5'(stall_o), 5'd0);
        chk("rst_exmem", exmem_rd_o, 5'd0);
        chk("rst_memwb", memwb_rd_o, 5'd0);

        rst_i = 1'b1;
        issue(5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        issue(5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        chk("idle_fwdA", 5'(forwardA_o), 5'd0);
        chk("idle_stall", 5'(stall_o), 5'd0);

        // Back-to-back: add x5; sub x6,x5,x5
        issue(5'd1, 5'd2, 5'd5, 1'b1, 1'b0);
        issue(5'd5, 5'd5, 5'd6, 1'b1, 1'b0);
        chk("b2b_fwdA", 5'(forwardA_o), 5'b10);
        chk("b2b_fwdB", 5'(forwardB_o), 5'b10);
        chk("b2b_exmem", exmem_rd_o, 5'd5);
        drain();

        // Distance 2: producer x7, filler, consumer rs2=7
        issue(5'd0, 5'd0, 5'd7, 1'b1, 1'b0);
        issue(5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        issue(5'd1, 5'd7, 5'd8, 1'b1, 1'b0);
        chk("d2_fwdB", 5'(forwardB_o), 5'b01);
        chk("d2_fwdA", 5'(forwardA_o), 5'b00);
        chk("d2_memwb", memwb_rd_o, 5'd7);
        drain();

        // Priority: two producers of x7, consumer rs1=7
        issue(5'd0, 5'd0, 5'd7, 1'b1, 1'b0);
        issue(5'd0, 5'd0, 5'd7, 1'b1, 1'b0);
        issue(5'd7, 5'd0, 5'd8, 1'b1, 1'b0);
        chk("prio_fwdA", 5'(forwardA_o), 5'b10);
        drain();

        // Load-use: lw x3, then consumer rs1=3 held in ID
        issue(5'd0, 5'd0, 5'd3, 1'b1, 1'b1);
        set_id(5'd3, 5'd0, 5'd4, 1'b1, 1'b0);
        #1;
        chk("lu_stall_on", 5'(stall_o), 5'd1);
        step();
        chk("lu_stall_off", 5'(stall_o), 5'd0);
        chk("lu_bubble_fwdA", 5'(forwardA_o), 5'b00);
        chk("lu_exmem", exmem_rd_o, 5'd3);
        step();
        chk("lu_fwdA", 5'(forwardA_o), 5'b01);
        chk("lu_stall_after", 5'(stall_o), 5'd0);
        drain();

        // x0 is never forwarded
        issue(5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
        issue(5'd0, 5'd0, 5'd1, 1'b1, 1'b0);
        chk("x0_fwdA", 5'(forwardA_o), 5'b00);
        chk("x0_fwdB", 5'(forwardB_o), 5'b00);
        drain();

        // Flushed producer x9 must not forward at distance 1 or 2
        set_id(5'd0, 5'd0, 5'd9, 1'b1, 1'b0);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        issue(5'd9, 5'd0, 5'd1, 1'b1, 1'b0);
        chk("flush_d1_fwdA", 5'(forwardA_o), 5'b00);
        issue(5'd0, 5'd9, 5'd1, 1'b1, 1'b0);
        chk("flush_d2_fwdB", 5'(forwardB_o), 5'b00);
        drain();

        // Async reset while stall and EX/MEM forward are both active
        issue(5'd0, 5'd0, 5'd2, 1'b1, 1'b0);
        issue(5'd2, 5'd0, 5'd3, 1'b1, 1'b1);
        set_id(5'd3, 5'd0, 5'd4, 1'b1, 1'b0);
        #1;
        chk("ar_pre_stall", 5'(stall_o), 5'd1);
        chk("ar_pre_fwdA", 5'(forwardA_o), 5'b10);
        #1;
        rst_i = 1'b0;
        #1;
        chk("ar_stall", 5'(stall_o), 5'd0);
        chk("ar_fwdA", 5'(forwardA_o), 5'b00);
        chk("ar_exmem", exmem_rd_o, 5'd0);
        #1;
        rst_i = 1'b1;
        issue(5'd2, 5'd3, 5'd4, 1'b1, 1'b0);
        chk("ar_post_fwdA", 5'(forwardA_o), 5'b00);
        chk("ar_post_fwdB", 5'(forwardB_o), 5'b00);
        chk("ar_post_stall", 5'(stall_o), 5'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
